// File: rtl/pc_redirect_ctrl.sv
// Next-PC sequencer for the fetch stage.
// It selects the next PC from five sources: exception vector, ERET return,
// EX-stage branch, ID-stage redirect, or sequential PC+4. A redirect that
// arrives while fetch is stalled is parked in a pending register. It is
// applied on the first unstalled cycle.
//
// state | meaning
// ------+-----------------------------------------------------------
// RUN   | no redirect waiting; live requests apply immediately
// PEND  | pend_target/pend_lvl hold a redirect waiting for the stall
//       | to release
module pc_redirect_ctrl #(
    parameter logic [31:0] RESET_PC   = 32'h00400000,
    parameter logic [31:0] EXC_VECTOR = 32'h00400004
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_cur,
    input  logic        fetch_block,
    input  logic        id_redir,
    input  logic [31:0] id_target,
    input  logic        ex_redir,
    input  logic [31:0] ex_target,
    input  logic        exc_req,
    input  logic [31:0] exc_pc,
    input  logic        eret_req,
    output logic [31:0] pc_next,
    output logic        pc_ena,
    output logic        flush_if,
    output logic        flush_id,
    output logic [31:0] epc,
    output logic        pending
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_PEND = 1'b1
    } state_t;

    localparam logic [1:0] LVL_ID   = 2'd0;
    localparam logic [1:0] LVL_EX   = 2'd1;
    localparam logic [1:0] LVL_ERET = 2'd2;
    localparam logic [1:0] LVL_EXC  = 2'd3;

    state_t      state_q, state_d;
    logic [31:0] pend_target_q, pend_target_d;
    logic [1:0]  pend_lvl_q, pend_lvl_d;
    logic [31:0] epc_q;

    logic        live_valid;
    logic [1:0]  live_lvl;
    logic [31:0] live_target;
    logic        use_live;
    logic [31:0] eff_target;
    logic [1:0]  eff_lvl;

    // Pick this cycle's highest-level request; lower ones are dropped.
    always_comb begin
        live_valid  = 1'b1;
        live_lvl    = LVL_ID;
        live_target = id_target;
        if (exc_req) begin
            live_lvl    = LVL_EXC;
            live_target = EXC_VECTOR;
        end else if (eret_req) begin
            live_lvl    = LVL_ERET;
            live_target = epc_q;
        end else if (ex_redir) begin
            live_lvl    = LVL_EX;
            live_target = ex_target;
        end else if (!id_redir) begin
            live_valid  = 1'b0;
        end
    end

    // Merge the live winner with the parked redirect; equal level overwrites.
    always_comb begin
        use_live   = live_valid && (live_lvl >= pend_lvl_q);
        eff_target = use_live ? live_target : pend_target_q;
        eff_lvl    = use_live ? live_lvl    : pend_lvl_q;
    end

    // Next-state, next-PC and flush strobes; reset overrides everything.
    always_comb begin
        state_d       = state_q;
        pend_target_d = pend_target_q;
        pend_lvl_d    = pend_lvl_q;
        pc_next       = pc_cur + 32'd4;
        pc_ena        = 1'b1;
        flush_if      = 1'b0;
        flush_id      = 1'b0;

        unique case (state_q)
            ST_RUN: begin
                if (live_valid) begin
                    pc_next = live_target;
                    if (fetch_block) begin
                        pend_target_d = live_target;
                        pend_lvl_d    = live_lvl;
                        state_d       = ST_PEND;
                    end else begin
                        flush_if = 1'b1;
                        flush_id = (live_lvl != LVL_ID);
                    end
                end
            end
            ST_PEND: begin
                if (fetch_block) begin
                    // The PC register is blocked, so pc_next shows the held target.
                    pc_next       = pend_target_q;
                    pend_target_d = eff_target;
                    pend_lvl_d    = eff_lvl;
                end else begin
                    pc_next  = eff_target;
                    flush_if = 1'b1;
                    flush_id = (eff_lvl != LVL_ID);
                    state_d  = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase

        if (rst) begin
            pc_next  = RESET_PC;
            pc_ena   = 1'b0;
            flush_if = 1'b1;
            flush_id = 1'b1;
        end
    end

    // State and pending-redirect registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_RUN;
            pend_target_q <= 32'd0;
            pend_lvl_q    <= 2'd0;
        end else begin
            state_q       <= state_d;
            pend_target_q <= pend_target_d;
            pend_lvl_q    <= pend_lvl_d;
        end
    end

    // Capture the faulting PC on every exception request, applied or parked.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            epc_q <= 32'd0;
        end else if (exc_req) begin
            epc_q <= exc_pc;
        end
    end

    assign epc     = epc_q;
    assign pending = (state_q == ST_PEND);

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Directed bench for pc_redirect_ctrl with hand-computed expectations.
module tb_pc_redirect_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_cur;
    logic        fetch_block;
    logic        id_redir;
    logic [31:0] id_target;
    logic        ex_redir;
    logic [31:0] ex_target;
    logic        exc_req;
    logic [31:0] exc_pc;
    logic        eret_req;
    logic [31:0] pc_next;
    logic        pc_ena;
    logic        flush_if;
    logic        flush_id;
    logic [31:0] epc;
    logic        pending;

    int n_chk  = 0;
    int n_pass = 0;

    pc_redirect_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .pc_cur      (pc_cur),
        .fetch_block (fetch_block),
        .id_redir    (id_redir),
        .id_target   (id_target),
        .ex_redir    (ex_redir),
        .ex_target   (ex_target),
        .exc_req     (exc_req),
        .exc_pc      (exc_pc),
        .eret_req    (eret_req),
        .pc_next     (pc_next),
        .pc_ena      (pc_ena),
        .flush_if    (flush_if),
        .flush_id    (flush_id),
        .epc         (epc),
        .pending     (pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_reqs();
        id_redir  = 1'b0;
        ex_redir  = 1'b0;
        exc_req   = 1'b0;
        eret_req  = 1'b0;
    endtask

    task automatic chk_flush(input string tag, input logic exp_if, input logic exp_id);
        chk({tag, ".flush_if"}, {31'd0, flush_if}, {31'd0, exp_if});
        chk({tag, ".flush_id"}, {31'd0, flush_id}, {31'd0, exp_id});
    endtask

    initial begin
        rst = 1'b1; pc_cur = 32'h00400000; fetch_block = 1'b0;
        id_target = 32'd0; ex_target = 32'd0; exc_pc = 32'd0;
        idle_reqs();
        step(); step();
        #1;
        chk("rst.pc_next", pc_next, 32'h00400000);
        chk("rst.pc_ena",  {31'd0, pc_ena}, 32'd0);
        chk_flush("rst", 1'b1, 1'b1);
        chk("rst.pending", {31'd0, pending}, 32'd0);
        chk("rst.epc", epc, 32'd0);

        // Sequential fetch and wrap.
        step();
        rst = 1'b0; pc_cur = 32'h00400000;
        #1;
        chk("seq.pc_next", pc_next, 32'h00400004);
        chk("seq.pc_ena", {31'd0, pc_ena}, 32'd1);
        chk_flush("seq", 1'b0, 1'b0);
        pc_cur = 32'hFFFFFFFC;
        #1;
        chk("wrap.pc_next", pc_next, 32'h00000000);

        // Same-cycle priority.
        step();
        pc_cur = 32'h00400010;
        id_redir = 1'b1; id_target = 32'h00400100;
        ex_redir = 1'b1; ex_target = 32'h00400200;
        #1;
        chk("prio_ex.pc_next", pc_next, 32'h00400200);
        chk_flush("prio_ex", 1'b1, 1'b1);
        exc_req = 1'b1; exc_pc = 32'h00400050;
        #1;
        chk("prio_exc.pc_next", pc_next, 32'h00400004);
        chk_flush("prio_exc", 1'b1, 1'b1);
        step();
        idle_reqs();
        #1;
        chk("prio_exc.epc", epc, 32'h00400050);
        chk("prio_exc.pending", {31'd0, pending}, 32'd0);

        // Stalled ID redirect.
        step();
        fetch_block = 1'b1; id_redir = 1'b1; id_target = 32'h00400300;
        #1;
        chk("stall1.pc_next", pc_next, 32'h00400300);
        chk_flush("stall1", 1'b0, 1'b0);
        step();
        id_redir = 1'b0;
        #1;
        chk("stall2.pending", {31'd0, pending}, 32'd1);
        chk("stall2.pc_next", pc_next, 32'h00400300);
        chk_flush("stall2", 1'b0, 1'b0);
        step();
        #1;
        chk("stall3.pending", {31'd0, pending}, 32'd1);
        chk_flush("stall3", 1'b0, 1'b0);
        step();
        fetch_block = 1'b0;
        #1;
        chk("stall4.pc_next", pc_next, 32'h00400300);
        chk_flush("stall4", 1'b1, 1'b0);
        step();
        pc_cur = 32'h00400300;
        #1;
        chk("stall5.pending", {31'd0, pending}, 32'd0);
        chk("stall5.pc_next", pc_next, 32'h00400304);
        chk_flush("stall5", 1'b0, 1'b0);

        // Pending overwrite rules.
        step();
        fetch_block = 1'b1; ex_redir = 1'b1; ex_target = 32'h00400400;
        step();
        ex_redir = 1'b0; id_redir = 1'b1; id_target = 32'h00400500;
        #1;
        chk("ovr_id.pending", {31'd0, pending}, 32'd1);
        chk("ovr_id.pc_next", pc_next, 32'h00400400);
        step();
        id_redir = 1'b0;
        #1;
        chk("ovr_kept.pc_next", pc_next, 32'h00400400);
        ex_redir = 1'b1; ex_target = 32'h00400600;
        step();
        ex_redir = 1'b0;
        #1;
        chk("ovr_ex.pc_next", pc_next, 32'h00400600);
        fetch_block = 1'b0;
        #1;
        chk("ovr_rel.pc_next", pc_next, 32'h00400600);
        chk_flush("ovr_rel", 1'b1, 1'b1);
        step();
        #1;
        chk("ovr_rel.pending", {31'd0, pending}, 32'd0);

        // Overwrite on the release cycle itself, then a lower request at release.
        fetch_block = 1'b1; id_redir = 1'b1; id_target = 32'h00400900;
        step();
        id_redir = 1'b0; fetch_block = 1'b0;
        ex_redir = 1'b1; ex_target = 32'h00400A00;
        #1;
        chk("relovr.pc_next", pc_next, 32'h00400A00);
        chk_flush("relovr", 1'b1, 1'b1);
        step();
        ex_redir = 1'b1; ex_target = 32'h00400B00; fetch_block = 1'b1;
        step();
        ex_redir = 1'b0; fetch_block = 1'b0;
        id_redir = 1'b1; id_target = 32'h00400C00;
        #1;
        chk("reldrop.pc_next", pc_next, 32'h00400B00);
        chk_flush("reldrop", 1'b1, 1'b1);
        step();
        idle_reqs();

        // Exception / ERET round trip.
        pc_cur = 32'h00400080;
        exc_req = 1'b1; exc_pc = 32'h00400080;
        #1;
        chk("exc.pc_next", pc_next, 32'h00400004);
        chk_flush("exc", 1'b1, 1'b1);
        step();
        exc_req = 1'b0; pc_cur = 32'h00400004;
        #1;
        chk("exc.epc", epc, 32'h00400080);
        chk("exc_seq.pc_next", pc_next, 32'h00400008);
        step();
        eret_req = 1'b1;
        #1;
        chk("eret.pc_next", pc_next, 32'h00400080);
        chk_flush("eret", 1'b1, 1'b1);
        step();
        eret_req = 1'b0;
        #1;
        chk("eret.epc_kept", epc, 32'h00400080);

        // Asynchronous reset in the middle of a PEND cycle.
        step();
        fetch_block = 1'b1; id_redir = 1'b1; id_target = 32'h00400700;
        step();
        id_redir = 1'b0;
        #1;
        chk("rstp.pending_before", {31'd0, pending}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("rstp.pending", {31'd0, pending}, 32'd0);
        chk("rstp.pc_next", pc_next, 32'h00400000);
        chk("rstp.pc_ena", {31'd0, pc_ena}, 32'd0);
        chk("rstp.epc", epc, 32'd0);
        chk_flush("rstp", 1'b1, 1'b1);
        step();
        rst = 1'b0; fetch_block = 1'b0; pc_cur = 32'h00400000;
        #1;
        chk("rstp_rel.pc_next", pc_next, 32'h00400004);
        chk_flush("rstp_rel", 1'b0, 1'b0);
        step();
        #1;
        chk("rstp_rel.pending", {31'd0, pending}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
